// File: rtl/csrisc_alu_pkg.sv
// Shared ALU definitions: slice width, add/sub FSM state encoding and NZCV flag layout.
package csrisc_alu_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Flag vector layout {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic int unsigned num_slices(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_16bit_lcu.sv
// 16-bit carry-lookahead adder: four 4-bit groups joined by a lookahead carry unit.
module cla_16bit_lcu (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] sum_o,
    output logic        c_o,
    output logic        p_o,
    output logic        g_o
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;

    always_comb begin
        p = a_i ^ b_i;
        g = a_i & b_i;
        gp = '0;
        gg = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end

        gc[0] = c_i;
        gc[1] = gg[0] | (gp[0] & c_i);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_i);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_i);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & c_i);

        // Within a group the carries ripple from the lookahead group carry-in
        c = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int unsigned j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end

        sum_o = p ^ c;
        c_o   = gc[4];
        p_o   = &gp;
        g_o   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);
    end

endmodule

// File: rtl/addsub32_seq.sv
// Multi-cycle WIDTH-bit add/subtract reusing one 16-bit CLA slice per cycle, low half first.
// Define ADDSUB_ADC_EN to take carry/borrow-in from op_cin (ADC/SBC).
module addsub32_seq
    import csrisc_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             op_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int unsigned NSLICE = num_slices(WIDTH);
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   result_q, result_d;
    flags_t             flags_q, flags_d;

    logic               c0;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_p;
    logic               slice_g;
    logic               unused_pg;
    logic [WIDTH-1:0]   res_mrg;

`ifdef ADDSUB_ADC_EN
    assign c0 = op_sub ? ~op_cin : op_cin;
`else
    logic unused_cin;
    assign c0         = op_sub;
    assign unused_cin = op_cin;
`endif

    assign slice_a   = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b   = b_q[idx_q*SLICE_W +: SLICE_W];
    assign unused_pg = slice_p ^ slice_g;

    cla_16bit_lcu u_slice (
        .a_i   (slice_a),
        .b_i   (slice_b),
        .c_i   (carry_q),
        .sum_o (slice_sum),
        .c_o   (slice_cout),
        .p_o   (slice_p),
        .g_o   (slice_g)
    );

    // Full result with the current pass merged in, so Z/N/V see every slice on the last pass
    always_comb begin
        res_mrg = result_q;
        res_mrg[idx_q*SLICE_W +: SLICE_W] = slice_sum;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        result_d  = result_q;
        flags_d   = flags_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b ^ {WIDTH{op_sub}};
                    carry_d = c0;
                    idx_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                result_d = res_mrg;
                carry_d  = slice_cout;
                if (idx_q == LAST_IDX) begin
                    flags_d.n = res_mrg[WIDTH-1];
                    flags_d.z = (res_mrg == '0);
                    flags_d.c = slice_cout;
                    flags_d.v = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                (res_mrg[WIDTH-1] != a_q[WIDTH-1]);
                    idx_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign flag_n = flags_q.n;
    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;

endmodule

// File: tb/tb_addsub32_seq.sv
// Self-checking bench for addsub32_seq: directed corner cases plus random ops against an arithmetic model.
module tb_addsub32_seq;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NSLICE = WIDTH / 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             op_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    int n_cmp = 0;
    int n_bad = 0;

    addsub32_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .op_cin    (op_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {N,Z,C,V,result} from unsigned/signed integer arithmetic
    function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sub, input logic cin);
        longint unsigned ua, ub, k, full;
        longint          sa, sb, sres;
        logic [31:0]     r;
        logic            c, v;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
`ifdef ADDSUB_ADC_EN
        k = {63'd0, cin};
`else
        k = 64'd0;
        if (cin) k = 64'd0;
`endif
        if (!sub) begin
            full = ua + ub + k;
            c    = full[32];
            sres = sa + sb + longint'(k);
        end else begin
            full = ua - ub - k;
            c    = (ua >= ub + k);
            sres = sa - sb - longint'(k);
        end
        r = full[31:0];
        v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic cin, input int unsigned hold, input string tag);
        logic [35:0]  exp;
        int unsigned  lat;
        int unsigned  wait_n;
        exp       = ref_model(a, b, sub, cin);
        op_a      = a;
        op_b      = b;
        op_sub    = sub;
        op_cin    = cin;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            step();
            wait_n++;
        end
        check({tag, " ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        op_sub   = 1'($urandom_range(0, 1));
        op_cin   = 1'($urandom_range(0, 1));
        check({tag, " busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(NSLICE));
        check({tag, " result"}, 64'(result), 64'(exp[31:0]));
        check({tag, " nzcv"}, 64'({flag_n, flag_z, flag_c, flag_v}), 64'(exp[35:32]));
        for (int unsigned i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            op_a     = $urandom;
            op_b     = $urandom;
            step();
            check({tag, " hold valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold ready"}, 64'(in_ready), 64'd0);
            check({tag, " hold result"}, 64'({flag_n, flag_z, flag_c, flag_v, result}), 64'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check({tag, " released"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        op_cin    = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("reset ctl", 64'({in_ready, out_valid}), 64'b10);
        check("reset result", 64'(result), 64'd0);
        check("reset flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'd0);
        rst = 1'b0;
        step();

        run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 0, "add_cross");
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b0, 0, "sub_neg");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, "add_ovf");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, "add_wrap");
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0, 0, "sub_ovf");
        run_op(32'h12345678, 32'h12345678, 1'b1, 1'b0, 0, "sub_zero");
        run_op(32'h00000001, 32'h00000001, 1'b0, 1'b1, 0, "adc_cin");
        run_op(32'h00000005, 32'h00000002, 1'b1, 1'b1, 0, "sbc_cin");
        run_op(32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0, 5, "hold5");

        // Reset during CALC after the first pass
        op_a = 32'h0000FFFF; op_b = 32'h00000001; op_sub = 1'b0; op_cin = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_calc ctl", 64'({in_ready, out_valid}), 64'b10);
        check("rst_calc result", 64'({flag_n, flag_z, flag_c, flag_v, result}), 64'd0);
        step();
        step();
        step();
        check("rst_calc discard", 64'(out_valid), 64'd0);
        run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 0, "after_rst_calc");

        // Reset while holding a result in DONE
        op_a = 32'h00000003; op_b = 32'h00000004; op_sub = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (NSLICE) step();
        check("rst_done pre", 64'(out_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_done ctl", 64'({in_ready, out_valid}), 64'b10);
        check("rst_done result", 64'({flag_n, flag_z, flag_c, flag_v, result}), 64'd0);
        out_ready = 1'b1;
        run_op(32'h00000003, 32'h00000004, 1'b1, 1'b0, 0, "after_rst_done");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 1) ra = 32'hFFFFFFFF;
            if (i % 8 == 2) rb = 32'h80000000;
            if (i % 8 == 3) rb = ra;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
